// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Shared definitions for the OLED command decoder: opcode
//                constants, addressing-mode encodings, decoder FSM states and
//                a helper that classifies opcodes whose argument is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

  // Addressing modes (2-bit field of opcode 0x20; 2'b11 is not a mode)
  localparam logic [1:0] ADDR_HORIZ = 2'b00;
  localparam logic [1:0] ADDR_VERT  = 2'b01;
  localparam logic [1:0] ADDR_PAGE  = 2'b10;

  // Multi-byte opcodes
  localparam logic [7:0] OP_SET_MODE      = 8'h20;
  localparam logic [7:0] OP_SET_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_SET_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_SET_CONTRAST  = 8'h81;

  // Single-byte opcodes (ranges handled by field match in the decoder)
  localparam logic [7:0] OP_PAGE_BASE     = 8'hB0;
  localparam logic [7:0] OP_SEG_NORMAL    = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP     = 8'hA1;
  localparam logic [7:0] OP_DISP_NORMAL   = 8'hA6;
  localparam logic [7:0] OP_DISP_INVERT   = 8'hA7;
  localparam logic [7:0] OP_DISPLAY_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON    = 8'hAF;
  localparam logic [7:0] OP_COM_NORMAL    = 8'hC0;
  localparam logic [7:0] OP_COM_REMAP     = 8'hC8;
  localparam logic [7:0] OP_NOP           = 8'hE3;

  // Opcodes whose single argument byte is accepted and discarded
  localparam logic [7:0] OP_MUX_RATIO     = 8'hA8;
  localparam logic [7:0] OP_DISP_OFFSET   = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV       = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE     = 8'hD9;
  localparam logic [7:0] OP_COM_PINS      = 8'hDA;
  localparam logic [7:0] OP_VCOMH         = 8'hDB;
  localparam logic [7:0] OP_CHARGE_PUMP   = 8'h8D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2,
    ST_SKIP = 2'd3
  } dec_state_t;

  function automatic logic is_skip_op(input logic [7:0] op);
    return (op == OP_MUX_RATIO) || (op == OP_DISP_OFFSET) ||
           (op == OP_CLK_DIV)   || (op == OP_PRECHARGE)   ||
           (op == OP_COM_PINS)  || (op == OP_VCOMH)       ||
           (op == OP_CHARGE_PUMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : oled_spi_rx
//  Description : SPI mode-0 byte receiver, MSB first. mosi is shifted in on
//                every detected scl rising edge while ss is low; dc is taken
//                together with the eighth bit. ss high clears the bit counter
//                and drops any partial byte.
//  Config      : OLED_CMD_DECODER_PIN_SYNC_EN adds 2-flop synchronisers on
//                all four pins; otherwise pins are used directly.
//  Ports       : clk, rst (async active-low)
//                ss, scl, mosi, dc  - SPI pins
//                rx_data, rx_dc     - received byte and its dc flag
//                rx_valid           - one-cycle pulse when a byte completes
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       scl,
  input  logic       mosi,
  input  logic       dc,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid
);

  logic ss_s, scl_s, mosi_s, dc_s;

`ifdef OLED_CMD_DECODER_PIN_SYNC_EN
  logic [1:0] ss_meta, scl_meta, mosi_meta, dc_meta;

  // ss resets to the deselected level so no false transfer start is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_meta   <= 2'b11;
      scl_meta  <= 2'b00;
      mosi_meta <= 2'b00;
      dc_meta   <= 2'b00;
    end else begin
      ss_meta   <= {ss_meta[0], ss};
      scl_meta  <= {scl_meta[0], scl};
      mosi_meta <= {mosi_meta[0], mosi};
      dc_meta   <= {dc_meta[0], dc};
    end
  end

  assign ss_s   = ss_meta[1];
  assign scl_s  = scl_meta[1];
  assign mosi_s = mosi_meta[1];
  assign dc_s   = dc_meta[1];
`else
  assign ss_s   = ss;
  assign scl_s  = scl;
  assign mosi_s = mosi;
  assign dc_s   = dc;
`endif

  logic       scl_q;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       scl_rise;

  assign scl_rise = scl_s & ~scl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q    <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      rx_data  <= 8'd0;
      rx_dc    <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      scl_q    <= scl_s;
      rx_valid <= 1'b0;
      if (ss_s) begin
        bit_cnt <= 3'd0;
      end else if (scl_rise) begin
        if (bit_cnt == 3'd7) begin
          rx_data  <= {shift, mosi_s};
          rx_dc    <= dc_s;
          rx_valid <= 1'b1;
          bit_cnt  <= 3'd0;
        end else begin
          shift   <= {shift[5:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : oled_cmd_decoder
//  Description : SSD1306-style command decoder. Bytes arriving with dc=1 are
//                written to the framebuffer at page*X_SIZE+col and advance the
//                column/page pointer according to the addressing mode. Bytes
//                with dc=0 are decoded as 1-, 2- or 3-byte commands.
//  Config      : OLED_CMD_DECODER_PIN_SYNC_EN - synchronise the SPI pins
//                (write latency 3 clk instead of 1 clk).
//  Ports       : clk, rst (async active-low)
//                ss, scl, mosi, dc          - SPI pins
//                fb_addr, fb_data, fb_wr    - framebuffer write port
//                display_on, invert, seg_remap, com_remap, contrast,
//                start_line                 - display state
//                cmd_err                    - one-cycle unknown-opcode pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_cmd_decoder
  import oled_pkg::*;
#(
  parameter int X_SIZE = 128,
  parameter int Y_SIZE = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ss,
  input  logic                                 scl,
  input  logic                                 mosi,
  input  logic                                 dc,
  output logic [$clog2(X_SIZE*(Y_SIZE/8))-1:0] fb_addr,
  output logic [7:0]                           fb_data,
  output logic                                 fb_wr,
  output logic                                 display_on,
  output logic                                 invert,
  output logic                                 seg_remap,
  output logic                                 com_remap,
  output logic [7:0]                           contrast,
  output logic [5:0]                           start_line,
  output logic                                 cmd_err
);

  localparam int PAGES = Y_SIZE / 8;
  localparam int AW    = $clog2(X_SIZE * PAGES);
  localparam int CW    = $clog2(X_SIZE);
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [7:0] COL_MAX  = 8'(X_SIZE - 1);
  localparam logic [7:0] PAGE_MAX = 8'(PAGES - 1);

  // Argument clamping to the physical display size
  function automatic logic [CW-1:0] col_arg(input logic [7:0] v);
    return (v > COL_MAX) ? COL_MAX[CW-1:0] : v[CW-1:0];
  endfunction

  function automatic logic [PW-1:0] page_arg(input logic [7:0] v);
    return (v > PAGE_MAX) ? PAGE_MAX[PW-1:0] : v[PW-1:0];
  endfunction

  // Pointer step: reload the window start on hitting the end, otherwise count
  // up modulo the display size. A pointer outside its window therefore keeps
  // counting (wrapping) until it reaches the end value.
  function automatic logic [CW-1:0] col_step(input logic [CW-1:0] cur,
                                             input logic [CW-1:0] lo,
                                             input logic [CW-1:0] hi);
    if (cur == hi) return lo;
    if (cur == COL_MAX[CW-1:0]) return '0;
    return cur + CW'(1);
  endfunction

  function automatic logic [PW-1:0] page_step(input logic [PW-1:0] cur,
                                              input logic [PW-1:0] lo,
                                              input logic [PW-1:0] hi);
    if (cur == hi) return lo;
    if (cur == PAGE_MAX[PW-1:0]) return '0;
    return cur + PW'(1);
  endfunction

  // --------------------------------------------------------------------------
  // SPI byte receiver
  // --------------------------------------------------------------------------
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;

  oled_spi_rx u_spi_rx (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .scl      (scl),
    .mosi     (mosi),
    .dc       (dc),
    .rx_data  (rx_data),
    .rx_dc    (rx_dc),
    .rx_valid (rx_valid)
  );

  // --------------------------------------------------------------------------
  // State and next-state signals
  // --------------------------------------------------------------------------
  dec_state_t    state, state_nx;
  logic [7:0]    op, op_nx;         // opcode awaiting its arguments
  logic [7:0]    arg, arg_nx;       // first argument of a 3-byte command
  logic [1:0]    mode, mode_nx;
  logic [CW-1:0] col, col_nx, col_start, col_start_nx, col_end, col_end_nx;
  logic [PW-1:0] page, page_nx, page_start, page_start_nx, page_end, page_end_nx;
  logic          display_on_nx, invert_nx, seg_remap_nx, com_remap_nx;
  logic [7:0]    contrast_nx;
  logic [5:0]    start_line_nx;
  logic          fb_wr_nx, cmd_err_nx;
  logic [7:0]    fb_data_nx;
  logic [AW-1:0] fb_addr_nx;
  logic [7:0]    col_cur8, col_new8;
  logic [CW-1:0] col_adv;
  logic [PW-1:0] page_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    op_nx         = op;
    arg_nx        = arg;
    mode_nx       = mode;
    col_nx        = col;
    page_nx       = page;
    col_start_nx  = col_start;
    col_end_nx    = col_end;
    page_start_nx = page_start;
    page_end_nx   = page_end;
    display_on_nx = display_on;
    invert_nx     = invert;
    seg_remap_nx  = seg_remap;
    com_remap_nx  = com_remap;
    contrast_nx   = contrast;
    start_line_nx = start_line;
    fb_wr_nx      = 1'b0;
    fb_data_nx    = fb_data;
    fb_addr_nx    = fb_addr;
    cmd_err_nx    = 1'b0;
    col_cur8      = 8'(col);
    col_new8      = col_cur8;
    col_adv       = col_step(col, col_start, col_end);
    page_adv      = page_step(page, page_start, page_end);

    if (rx_valid && rx_dc) begin
      // Pixel data: written in any FSM state, which is left untouched
      fb_wr_nx   = 1'b1;
      fb_data_nx = rx_data;
      fb_addr_nx = AW'(page) * AW'(X_SIZE) + AW'(col);
      case (mode)
        ADDR_HORIZ: begin
          col_nx = col_adv;
          if (col == col_end) page_nx = page_adv;
        end
        ADDR_VERT: begin
          page_nx = page_adv;
          if (page == page_end) col_nx = col_adv;
        end
        default: col_nx = col_adv;
      endcase
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data[7:4] == 4'h0) begin
            col_new8 = {col_cur8[7:4], rx_data[3:0]};
            col_nx   = col_arg(col_new8);
          end else if (rx_data[7:4] == 4'h1) begin
            col_new8 = {rx_data[3:0], col_cur8[3:0]};
            col_nx   = col_arg(col_new8);
          end else if (rx_data[7:6] == 2'b01) begin
            start_line_nx = rx_data[5:0];
          end else if (rx_data[7:3] == OP_PAGE_BASE[7:3]) begin
            page_nx = page_arg({5'd0, rx_data[2:0]});
          end else begin
            case (rx_data)
              OP_DISPLAY_OFF: display_on_nx = 1'b0;
              OP_DISPLAY_ON:  display_on_nx = 1'b1;
              OP_DISP_NORMAL: invert_nx     = 1'b0;
              OP_DISP_INVERT: invert_nx     = 1'b1;
              OP_SEG_NORMAL:  seg_remap_nx  = 1'b0;
              OP_SEG_REMAP:   seg_remap_nx  = 1'b1;
              OP_COM_NORMAL:  com_remap_nx  = 1'b0;
              OP_COM_REMAP:   com_remap_nx  = 1'b1;
              OP_NOP:         ;
              OP_SET_CONTRAST, OP_SET_MODE, OP_SET_COL_ADDR, OP_SET_PAGE_ADDR: begin
                op_nx    = rx_data;
                state_nx = ST_ARG1;
              end
              default: begin
                if (is_skip_op(rx_data)) state_nx = ST_SKIP;
                else                     cmd_err_nx = 1'b1;
              end
            endcase
          end
        end
        ST_ARG1: begin
          state_nx = ST_IDLE;
          case (op)
            OP_SET_CONTRAST: contrast_nx = rx_data;
            OP_SET_MODE: begin
              if (rx_data[1:0] != 2'b11) mode_nx = rx_data[1:0];
            end
            OP_SET_COL_ADDR, OP_SET_PAGE_ADDR: begin
              arg_nx   = rx_data;
              state_nx = ST_ARG2;
            end
            default: ;
          endcase
        end
        ST_ARG2: begin
          state_nx = ST_IDLE;
          if (op == OP_SET_COL_ADDR) begin
            col_start_nx = col_arg(arg);
            col_end_nx   = col_arg(rx_data);
            col_nx       = col_arg(arg);
          end else begin
            page_start_nx = page_arg(arg);
            page_end_nx   = page_arg(rx_data);
            page_nx       = page_arg(arg);
          end
        end
        default: state_nx = ST_IDLE;  // ST_SKIP: argument discarded
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op         <= 8'd0;
      arg        <= 8'd0;
      mode       <= ADDR_PAGE;
      col        <= '0;
      page       <= '0;
      col_start  <= '0;
      col_end    <= COL_MAX[CW-1:0];
      page_start <= '0;
      page_end   <= PAGE_MAX[PW-1:0];
      display_on <= 1'b0;
      invert     <= 1'b0;
      seg_remap  <= 1'b0;
      com_remap  <= 1'b0;
      contrast   <= 8'h7F;
      start_line <= 6'd0;
      fb_wr      <= 1'b0;
      fb_data    <= 8'd0;
      fb_addr    <= '0;
      cmd_err    <= 1'b0;
    end else begin
      op         <= op_nx;
      arg        <= arg_nx;
      mode       <= mode_nx;
      col        <= col_nx;
      page       <= page_nx;
      col_start  <= col_start_nx;
      col_end    <= col_end_nx;
      page_start <= page_start_nx;
      page_end   <= page_end_nx;
      display_on <= display_on_nx;
      invert     <= invert_nx;
      seg_remap  <= seg_remap_nx;
      com_remap  <= com_remap_nx;
      contrast   <= contrast_nx;
      start_line <= start_line_nx;
      fb_wr      <= fb_wr_nx;
      fb_data    <= fb_data_nx;
      fb_addr    <= fb_addr_nx;
      cmd_err    <= cmd_err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_oled_cmd_decoder
//  Description : Self-checking bench for oled_cmd_decoder. Directed sequences
//                followed by randomized command/data traffic, all checked
//                against a byte-level reference model of the command set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_cmd_decoder;

  localparam int X = 128;
  localparam int Y = 64;
  localparam int P = Y / 8;
`ifdef OLED_CMD_DECODER_PIN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss = 1'b1, scl = 1'b0, mosi = 1'b0, dc = 1'b0;
  logic [9:0] fb_addr;
  logic [7:0] fb_data, contrast;
  logic [5:0] start_line;
  logic       fb_wr, display_on, invert, seg_remap, com_remap, cmd_err;

  always #5 clk = ~clk;

  oled_cmd_decoder #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .clk(clk), .rst(rst), .ss(ss), .scl(scl), .mosi(mosi), .dc(dc),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wr(fb_wr),
    .display_on(display_on), .invert(invert), .seg_remap(seg_remap),
    .com_remap(com_remap), .contrast(contrast), .start_line(start_line),
    .cmd_err(cmd_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: byte-level view of the command set
  // --------------------------------------------------------------------------
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode;  // mode: 0 H, 1 V, 2 P
  int m_disp, m_inv, m_seg, m_com, m_contrast, m_start;
  int cmdq[$];
  int e_wr, e_addr, e_err;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int cmd_len(input int op);
    case (op)
      'h81, 'h20:                                  return 2;
      'h21, 'h22:                                  return 3;
      'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'h8D:     return 2;
      default:                                     return 1;
    endcase
  endfunction

  // Next pointer value: back to start at end, otherwise +1 modulo size
  function automatic int step(input int cur, input int s, input int e, input int size);
    return (cur == e) ? s : (cur + 1) % size;
  endfunction

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = X - 1; m_ps = 0; m_pe = P - 1;
    m_mode = 2; m_disp = 0; m_inv = 0; m_seg = 0; m_com = 0;
    m_contrast = 'h7F; m_start = 0;
    cmdq.delete();
  endtask

  task automatic model_exec();
    int op;
    op = cmdq[0];
    if (cmdq.size() == 1) begin
      if (op < 'h10)                    m_col = mn((m_col & 'hF0) | (op & 'hF), X - 1);
      else if (op < 'h20)               m_col = mn(((op & 'hF) << 4) | (m_col & 'hF), X - 1);
      else if (op >= 'h40 && op <= 'h7F) m_start = op & 'h3F;
      else if (op >= 'hB0 && op <= 'hB7) m_page = mn(op & 7, P - 1);
      else begin
        case (op)
          'hAE: m_disp = 0;  'hAF: m_disp = 1;
          'hA6: m_inv  = 0;  'hA7: m_inv  = 1;
          'hA0: m_seg  = 0;  'hA1: m_seg  = 1;
          'hC0: m_com  = 0;  'hC8: m_com  = 1;
          'hE3: ;
          default: e_err = 1;
        endcase
      end
    end else if (cmdq.size() == 2) begin
      if (op == 'h81) m_contrast = cmdq[1];
      else if (op == 'h20 && (cmdq[1] & 3) != 3) m_mode = cmdq[1] & 3;
    end else begin
      if (op == 'h21) begin
        m_cs = mn(cmdq[1], X - 1); m_ce = mn(cmdq[2], X - 1); m_col = m_cs;
      end else begin
        m_ps = mn(cmdq[1], P - 1); m_pe = mn(cmdq[2], P - 1); m_page = m_ps;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic d);
    int wrap;
    e_wr = 0; e_err = 0; e_addr = 0;
    if (d) begin
      e_wr = 1;
      e_addr = m_page * X + m_col;
      if (m_mode == 0) begin
        wrap = (m_col == m_ce);
        m_col = step(m_col, m_cs, m_ce, X);
        if (wrap) m_page = step(m_page, m_ps, m_pe, P);
      end else if (m_mode == 1) begin
        wrap = (m_page == m_pe);
        m_page = step(m_page, m_ps, m_pe, P);
        if (wrap) m_col = step(m_col, m_cs, m_ce, X);
      end else begin
        m_col = step(m_col, m_cs, m_ce, X);
      end
    end else begin
      cmdq.push_back(int'(b));
      if (cmdq.size() == cmd_len(cmdq[0])) begin
        model_exec();
        cmdq.delete();
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // SPI driver and observation
  // --------------------------------------------------------------------------
  int ob_wr_cycles, ob_wr_first, ob_err_cycles, ob_err_first;
  logic [9:0] ob_addr;
  logic [7:0] ob_data;

  task automatic send_byte(input logic [7:0] b, input logic d);
    ss = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); scl = 1'b0; mosi = b[i]; dc = d;
      @(negedge clk);
      @(negedge clk); scl = 1'b1;
      if (i > 0) @(negedge clk);
    end
    ob_wr_cycles = 0; ob_wr_first = 0; ob_err_cycles = 0; ob_err_first = 0;
    ob_addr = '0; ob_data = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (fb_wr === 1'b1) begin
        if (ob_wr_cycles == 0) begin
          ob_wr_first = n; ob_addr = fb_addr; ob_data = fb_data;
        end
        ob_wr_cycles++;
      end
      if (cmd_err === 1'b1) begin
        if (ob_err_cycles == 0) ob_err_first = n;
        ob_err_cycles++;
      end
    end
    scl = 1'b0;
  endtask

  task automatic partial_bits(input logic [7:0] b, input logic d, input int n);
    ss = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); scl = 1'b0; mosi = b[7-i]; dc = d;
      @(negedge clk);
      @(negedge clk); scl = 1'b1;
      @(negedge clk);
    end
    @(negedge clk); scl = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_display_on"}, display_on, m_disp);
    check({tag, "_invert"},     invert,     m_inv);
    check({tag, "_seg_remap"},  seg_remap,  m_seg);
    check({tag, "_com_remap"},  com_remap,  m_com);
    check({tag, "_contrast"},   contrast,   m_contrast);
    check({tag, "_start_line"}, start_line, m_start);
  endtask

  task automatic do_byte(input logic [7:0] b, input logic d, input string tag);
    model_byte(b, d);
    send_byte(b, d);
    check({tag, "_wr_cycles"}, ob_wr_cycles, e_wr);
    if (e_wr != 0) begin
      check({tag, "_wr_latency"}, ob_wr_first, LAT + 1);
      check({tag, "_addr"}, ob_addr, e_addr);
      check({tag, "_data"}, ob_data, b);
    end
    check({tag, "_err_cycles"}, ob_err_cycles, e_err);
    if (e_err != 0) check({tag, "_err_latency"}, ob_err_first, LAT + 1);
    check_flags(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fb_wr"},   fb_wr,   0);
    check({tag, "_cmd_err"}, cmd_err, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_fb_data"}, fb_data, 0);
    check({tag, "_display_on"}, display_on, 0);
    check({tag, "_invert"},     invert,     0);
    check({tag, "_seg_remap"},  seg_remap,  0);
    check({tag, "_com_remap"},  com_remap,  0);
    check({tag, "_start_line"}, start_line, 0);
    check({tag, "_contrast"},   contrast,   'h7F);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int exp33[5] = '{894, 895, 1022, 1023, 894};
  logic [7:0] flag_ops[9] = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'hE3};
  logic [7:0] skip_ops[7] = '{8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D};
  logic [7:0] r_op;
  int         r_sel, r_nargs;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Default page mode: two data bytes, then col still 2 after 0x10
    do_byte(8'h11, 1'b1, "d32a"); check("d32a_addr_lit", ob_addr, 0); check("d32a_data_lit", ob_data, 'h11);
    do_byte(8'h22, 1'b1, "d32b"); check("d32b_addr_lit", ob_addr, 1); check("d32b_data_lit", ob_data, 'h22);
    do_byte(8'h10, 1'b0, "d32c");
    do_byte(8'h33, 1'b1, "d32d"); check("d32d_addr_lit", ob_addr, 2);

    // Horizontal mode inside a 2x2 window in the bottom-right corner
    do_byte(8'h20, 1'b0, "d33"); do_byte(8'h00, 1'b0, "d33");
    do_byte(8'h21, 1'b0, "d33"); do_byte(8'h7E, 1'b0, "d33"); do_byte(8'h7F, 1'b0, "d33");
    do_byte(8'h22, 1'b0, "d33"); do_byte(8'h06, 1'b0, "d33"); do_byte(8'h07, 1'b0, "d33");
    for (int i = 0; i < 5; i++) begin
      do_byte(8'(8'hA0 + i), 1'b1, "d33w");
      check("d33_addr_lit", ob_addr, exp33[i]);
    end

    // Vertical mode over the full screen
    do_byte(8'h20, 1'b0, "d34"); do_byte(8'h01, 1'b0, "d34");
    do_byte(8'h22, 1'b0, "d34"); do_byte(8'h00, 1'b0, "d34"); do_byte(8'h07, 1'b0, "d34");
    do_byte(8'h21, 1'b0, "d34"); do_byte(8'h00, 1'b0, "d34"); do_byte(8'h7F, 1'b0, "d34");
    for (int i = 0; i < 9; i++) begin
      do_byte(8'(8'h50 + i), 1'b1, "d34w");
      check("d34_addr_lit", ob_addr, (i < 8) ? i * 128 : 1);
    end

    // Display state flags; skip command swallows 0xAF
    do_byte(8'h81, 1'b0, "d35"); do_byte(8'h33, 1'b0, "d35");
    do_byte(8'hAF, 1'b0, "d35"); do_byte(8'hA7, 1'b0, "d35"); do_byte(8'h55, 1'b0, "d35");
    check("d35_contrast_lit", contrast, 'h33);
    check("d35_display_on_lit", display_on, 1);
    check("d35_invert_lit", invert, 1);
    check("d35_start_line_lit", start_line, 'h15);
    do_byte(8'hAE, 1'b0, "d35");
    do_byte(8'hD5, 1'b0, "d35s"); do_byte(8'hAF, 1'b0, "d35s");
    check("d35_skip_display_on_lit", display_on, 0);

    // Unknown opcode, then aborted partial byte before 0xB3
    do_byte(8'h20, 1'b0, "d36"); do_byte(8'h02, 1'b0, "d36");
    do_byte(8'h00, 1'b0, "d36"); do_byte(8'h10, 1'b0, "d36");
    do_byte(8'hFF, 1'b0, "d36e"); check("d36_err_cycles_lit", ob_err_cycles, 1);
    partial_bits(8'h00, 1'b1, 5);
    @(negedge clk); ss = 1'b1;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
    do_byte(8'hB3, 1'b0, "d36p"); check("d36_b3_no_write_lit", ob_wr_cycles, 0);
    do_byte(8'h99, 1'b1, "d36w"); check("d36_page3_addr_lit", ob_addr, 384);

    // Reset in the middle of a byte: outputs clear at once, next byte clean
    partial_bits(8'hC3, 1'b1, 4);
    @(negedge clk); #1 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_byte(8'h5A, 1'b1, "rst_mid"); check("rst_mid_addr_lit", ob_addr, 0);

    // Randomized traffic with interleaved data bytes inside commands
    for (int k = 0; k < 120; k++) begin
      r_sel = $urandom_range(0, 13);
      if (r_sel < 4) begin
        do_byte(8'($urandom), 1'b1, "rnd_data");
      end else begin
        case (r_sel)
          4:  r_op = 8'($urandom_range(0, 31));
          5:  r_op = 8'($urandom_range(8'hB0, 8'hB7));
          6:  r_op = 8'($urandom_range(8'h40, 8'h7F));
          7:  r_op = flag_ops[$urandom_range(0, 8)];
          8:  r_op = 8'h81;
          9:  r_op = 8'h20;
          10: r_op = 8'h21;
          11: r_op = 8'h22;
          12: r_op = skip_ops[$urandom_range(0, 6)];
          default: r_op = 8'($urandom);
        endcase
        r_nargs = cmd_len(int'(r_op)) - 1;
        do_byte(r_op, 1'b0, "rnd_cmd");
        for (int a = 0; a < r_nargs; a++) begin
          if ($urandom_range(0, 3) == 0) do_byte(8'($urandom), 1'b1, "rnd_mid_data");
          do_byte(8'($urandom), 1'b0, "rnd_arg");
        end
      end
    end
    do_byte(8'h77, 1'b1, "rnd_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oled_cmd_decoder.md
OLED_CMD_DECODER -- requirements
Module: oled_cmd_decoder

Interface
REQ-001 SHALL have parameter X_SIZE, default 128, meaning display columns (power of 2, 32..256).
REQ-002 SHALL have parameter Y_SIZE, default 64, meaning display rows (multiple of 8, 8..64); PAGES = Y_SIZE/8.
REQ-003 SHALL have port clk, input, 1, meaning the single clock.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports ss, scl, mosi and dc, each input, 1, meaning SPI select (active-low), SPI clock, SPI data and data/command select.
REQ-006 SHALL have port fb_addr, output, clog2(X_SIZE*PAGES), meaning framebuffer byte address = page*X_SIZE + col.
REQ-007 SHALL have ports fb_data (output, 8, pixel byte, bit0 = top row of page) and fb_wr (output, 1, one-cycle write strobe).
REQ-008 SHALL have ports display_on, invert, seg_remap and com_remap, each output, 1, meaning the display state flags.
REQ-009 SHALL have ports contrast (output, 8) and start_line (output, 6).
REQ-010 SHALL have port cmd_err, output, 1, meaning a one-cycle pulse on an unknown opcode.

Function
REQ-011 SHALL sample the SPI bus as mode 0, MSB first: mosi is captured on each detected scl rising edge while ss=0, and dc is captured with bit 7 (the eighth bit).
REQ-012 SHALL reset the bit counter and discard partial bits whenever ss=1; decoder FSM state SHALL be kept across ss toggles.
REQ-013 SHALL register fb_wr/fb_data/fb_addr exactly 1 clk after the edge detecting the eighth scl rise of a dc=1 byte, and advance the pointer on that same edge.
REQ-014 SHALL run FSM states IDLE, ARG1, ARG2 and SKIP, where SKIP discards exactly one argument byte; a dc=1 byte SHALL be written in any state and leave the state unchanged.
REQ-015 SHALL decode single-byte opcodes with no state change: 0x00-0x0F sets col[3:0]; 0x10-0x1F sets col[7:4]; 0xB0+n sets page n; 0x40-0x7F sets start_line; 0xAE/0xAF sets display_on; 0xA6/0xA7 sets invert; 0xA0/0xA1 sets seg_remap; 0xC0/0xC8 sets com_remap; 0xE3 is NOP.
REQ-016 SHALL decode two-byte opcodes IDLE->ARG1->IDLE: 0x81 sets contrast; 0x20 sets mode from arg[1:0] (00 horizontal, 01 vertical, 10 page, 11 ignored).
REQ-017 SHALL decode three-byte opcodes IDLE->ARG1->ARG2->IDLE: 0x21 sets col_start/col_end and sets col=col_start; 0x22 sets page_start/page_end and sets page=page_start.
REQ-018 SHALL send opcodes 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB and 0x8D IDLE->SKIP->IDLE.
REQ-019 SHALL stay in IDLE on any other opcode, pulse cmd_err for 1 clk, and change no register.
REQ-020 SHALL clamp column arguments to X_SIZE-1 and page arguments to PAGES-1.
REQ-021 SHALL advance in horizontal mode as col++; at col==col_end, col=col_start and page++; at page==page_end, page=page_start.
REQ-022 SHALL advance in vertical mode as page++; at page==page_end, page=page_start and col++; at col==col_end, col=col_start.
REQ-023 SHALL advance in page mode as col++; at col==col_end, col=col_start and page is unchanged.
REQ-024 SHALL, when a pointer is outside its [start,end] window (start>end or set via nibble opcodes), increment modulo X_SIZE / PAGES until it hits the end value.

Reset
REQ-025 SHALL, on rst=0, immediately set fb_wr=0, cmd_err=0, fb_addr=0, fb_data=0, display_on=0, invert=0, seg_remap=0, com_remap=0, start_line=0, contrast=0x7F.
REQ-026 SHALL, on rst=0, also set mode=page, col=page=0, col_start=0, col_end=X_SIZE-1, page_start=0, page_end=PAGES-1, FSM=IDLE, bit counter=0.
REQ-027 SHALL discard a byte in flight on reset mid-transfer; the first full byte after release is decoded normally.

Configuration
REQ-028 SHALL, with OLED_CMD_DECODER_PIN_SYNC_EN defined, pass ss/scl/mosi/dc through 2-flop synchronisers, adding 2 clk to REQ-013 latency (3 clk total).
REQ-029 SHALL, without OLED_CMD_DECODER_PIN_SYNC_EN, use the pins directly (source assumed in clk domain), with only the 1-flop scl edge-detect history kept.

Structure
REQ-030 SHALL place opcode constants, mode encodings (ADDR_HORIZ/ADDR_VERT/ADDR_PAGE) and the FSM state enum in shared package oled_pkg.
REQ-031 SHALL contain one sub-module, oled_spi_rx (sampling, bit counter, byte+dc valid pulse); decode and pointer logic SHALL sit in oled_cmd_decoder.

Verification
REQ-032 SHALL cover: reset, then data bytes 0x11, 0x22 (default page mode) -> fb_wr at addr 0 then 1, data 0x11/0x22, col=2.
REQ-033 SHALL cover: 0x20 0x00, 0x21 0x7E 0x7F, 0x22 0x06 0x07, then 5 data bytes -> addrs 894, 895, 1022, 1023, 894.
REQ-034 SHALL cover: 0x20 0x01, 0x22 0x00 0x07, 0x21 0x00 0x7F, then 9 data bytes -> addrs 0, 128, ..., 896, then 1.
REQ-035 SHALL cover: 0x81 0x33, 0xAF, 0xA7, 0x55 -> contrast=0x33, display_on=1, invert=1, start_line=0x15; 0xD5 0xAF -> display_on unchanged.
REQ-036 SHALL cover: opcode 0xFF -> cmd_err 1 clk, no state change; ss raised after 5 bits then 0xB3 sent -> page=3, no write.
